uart_tx: RTL and testbench

//  Serial UART transmitter, 8N1 by default, LSB first. Pairs with the team's UART receiver on the same
//  16x-oversample baud tick. Accepts one parallel byte per start request and shifts it out
//  on o_tx_serial as start bit, data bits and stop bit(s). Signals busy while shifting and

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the common frame defaults, the one-hot state encoding and a counter-width helper.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } uart_state_e;

    // Minimum one bit so a degenerate count of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop period, all timed on the
// shared oversample baud tick. Every output is a flop so the serial line never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int STOP_TICKS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_serial,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int TICK_W = cnt_width((OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS);
    localparam int BIT_W  = cnt_width(DATA_BITS);

    localparam logic [TICK_W-1:0] BIT_LAST_TICK  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST_TICK = TICK_W'(STOP_TICKS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT       = BIT_W'(DATA_BITS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE       = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ONE        = BIT_W'(1);

    uart_state_e          state, state_nx;
    logic [TICK_W-1:0]    tick_cnt, tick_cnt_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic                 serial_nx, busy_nx, done_nx;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_tx_serial <= 1'b1;
            o_tx_busy   <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            shift       <= shift_nx;
            o_tx_serial <= serial_nx;
            o_tx_busy   <= busy_nx;
            o_tx_done   <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift;
        done_nx     = 1'b0;

        case (state)
            // A tick coinciding with accept is deliberately not counted.
            ST_IDLE: begin
                if (i_tx_start) begin
                    shift_nx    = i_tx_data;
                    tick_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    state_nx    = ST_START;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt == BIT_LAST_TICK) begin
                        tick_cnt_nx = '0;
                        state_nx    = ST_DATA;
                    end else begin
                        tick_cnt_nx = tick_cnt + TICK_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt == BIT_LAST_TICK) begin
                        tick_cnt_nx = '0;
                        shift_nx    = shift >> 1;
                        if (bit_cnt == LAST_BIT) state_nx = ST_STOP;
                        else                     bit_cnt_nx = bit_cnt + BIT_ONE;
                    end else begin
                        tick_cnt_nx = tick_cnt + TICK_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_cnt == STOP_LAST_TICK) begin
                        tick_cnt_nx = '0;
                        state_nx    = ST_IDLE;
                        done_nx     = 1'b1;
                    end else begin
                        tick_cnt_nx = tick_cnt + TICK_ONE;
                    end
                end
            end
            default: begin
                state_nx    = ST_IDLE;
                tick_cnt_nx = '0;
                bit_cnt_nx  = '0;
            end
        endcase

        // Line level is decoded from the next state so the serial flop changes with the state.
        case (state_nx)
            ST_START: serial_nx = 1'b0;
            ST_DATA:  serial_nx = shift_nx[0];
            default:  serial_nx = 1'b1;
        endcase
        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model (ticks elapsed since accept) predicts the line, busy
// and done every cycle; directed literal checks pin the model on known frames.
module tb_uart_tx;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int ST    = 16;
    localparam int FRAME = (1 + DB) * OS + ST;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          start;
    logic [DB-1:0] data;
    logic          ser, busy, done;

    int checks = 0;
    int errors = 0;
    int tick_mode = 2;

    uart_tx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_TICKS(ST)) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_tick     (tick),
        .i_tx_start (start),
        .i_tx_data  (data),
        .o_tx_serial(ser),
        .o_tx_busy  (busy),
        .o_tx_done  (done)
    );

    always #5 clk = ~clk;

    // Tick source: 0 random, 1 every 4th clock, 2 none, 3 every clock.
    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0:       tick = ($urandom_range(0, 2) == 0);
                1:       begin div = (div + 1) % 4; tick = (div == 0); end
                3:       tick = 1'b1;
                default: tick = 1'b0;
            endcase
        end
    end

    // Frame model: a frame is just a count of ticks since accept.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_el   = 0;
    logic [DB-1:0] m_byte = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_el   <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_el   <= 0;
                    m_byte <= data;
                end
            end else if (tick) begin
                m_el <= m_el + 1;
                if (m_el + 1 == FRAME) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    function automatic logic exp_ser();
        int k;
        if (!m_busy) return 1'b1;
        k = m_el / OS;
        if (k == 0)  return 1'b0;
        if (k <= DB) return m_byte[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        checks = checks + 3;
        if (ser !== exp_ser()) begin
            errors++;
            $display("FAIL serial t=%0t got %b want %b", $time, ser, exp_ser());
        end
        if (busy !== m_busy) begin
            errors++;
            $display("FAIL busy t=%0t got %b want %b", $time, busy, m_busy);
        end
        if (done !== m_done) begin
            errors++;
            $display("FAIL done t=%0t got %b want %b", $time, done, m_done);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk("wait_idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send(input logic [DB-1:0] d);
        @(posedge clk);
        #1 start = 1'b1; data = d;
        @(posedge clk);
        #1 start = 1'b0; data = DB'($urandom);
    endtask

    // Counts ticks from the current point until n have elapsed (bounded).
    task automatic wait_ticks(input int n);
        int tk;
        tk = 0;
        for (int c = 0; c < 20000 && tk < n; c++) begin
            @(posedge clk);
            if (tick) tk++;
        end
        chk("wait_ticks_timeout", tk, n);
    endtask

    initial begin
        bit pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int tk, nd, gaps;
        bit got, t_now;

        rst_n = 1'b0; start = 1'b0; data = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_serial", ser, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 0xA5 with a tick every 4 clocks: sample each line level mid-bit.
        tick_mode = 1;
        repeat (3) @(posedge clk);
        send(8'hA5);
        tk = 0; got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(posedge clk);
            t_now = tick;
            if (t_now) tk++;
            #2;
            if (t_now && (tk % 16) == 8 && tk / 16 < 10)
                chk($sformatf("a5_level%0d", tk / 16), ser, pat[tk/16]);
            if (done) begin
                got = 1'b1;
                chk("a5_done_ticks", tk, 160);
            end
        end
        chk("a5_done_seen", {31'd0, got}, 1);

        // Start pulse with 0x11 in the middle of a 0x80 frame must be ignored.
        tick_mode = 0;
        wait_idle(100);
        send(8'h80);
        wait_ticks(40);
        #1 start = 1'b1; data = 8'h11;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0; gaps = 0; got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (done) begin nd++; got = 1'b1; end
            else if (!busy) gaps++;
        end
        repeat (50) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("busy_ignore_done_cnt", nd, 1);
        chk("busy_ignore_gaps", gaps, 0);

        // Back-to-back with start held: one idle clock after done, then the next start bit.
        wait_idle(100);
        @(posedge clk);
        #1 start = 1'b1; data = 8'h55;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("b2b_first_done", {31'd0, got}, 1);
        chk("b2b_gap_serial", ser, 1);
        chk("b2b_gap_busy", busy, 0);
        @(negedge clk);
        chk("b2b_restart_serial", ser, 0);
        chk("b2b_restart_busy", busy, 1);
        #1 start = 1'b0;
        wait_idle(3000);

        // Reset in the middle of a 0x0F frame, while the line is low (data bit 4).
        send(8'h0F);
        wait_ticks(16 * 5 + 5);
        #2;
        chk("rst_mid_pre_serial", ser, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_serial", ser, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h0F);
        wait_idle(3000);

        // Randomized traffic: start held for random spans, data changing every clock.
        for (int it = 0; it < 30; it++) begin
            tick_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
            @(posedge clk);
            #1 start = 1'b1;
            repeat ($urandom_range(1, 400)) begin
                data = DB'($urandom);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (it % 10 == 7) begin
                #2 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        tick_mode = 3;
        wait_idle(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
